// File: rtl/sub_seq_slice_32_bit_pkg.sv
// Shared ALU definitions for the sequential subtractor: FSM encoding,
// default datapath geometry and the signed-overflow helper.
package sub_seq_slice_32_bit_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_SLICE = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Signed overflow of a - b: operands of different sign and the result
   // sign differs from the minuend.
   function automatic logic signed_ovf(input logic a_msb,
                                       input logic b_msb,
                                       input logic d_msb);
      return (a_msb != b_msb) && (d_msb != a_msb);
   endfunction

endpackage

// File: rtl/sub_seq_slice_32_bit_if.sv
// Operand/result handshake bundle of the sequential subtractor.
// The slave side is the subtractor, the master side is its client.
interface sub_seq_slice_32_bit_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
   logic             overflow;
   logic             zero;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, diff, borrow_out, overflow, zero
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, diff, borrow_out, overflow, zero
   );
endinterface

// File: rtl/sub_seq_slice_32_bit_slice.sv
// One combinational subtract slice: d = a + ~b + cin, built from
// generate/propagate terms on a and ~b like the adder slices.
module sub_slice_8_bit #(
   parameter int SLICE = 8
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             cin,
   output logic [SLICE-1:0] d,
   output logic             cout
);
   logic [SLICE-1:0] nb_s;
   logic [SLICE-1:0] g_s;
   logic [SLICE-1:0] p_s;
   logic [SLICE:0]   c_s;

   assign nb_s = ~b;
   assign g_s  = a & nb_s;
   assign p_s  = a ^ nb_s;

   // Carry recurrence c[i+1] = g[i] | p[i] & c[i], seeded by the slice carry-in.
   always_comb begin
      c_s    = {(SLICE + 1){1'b0}};
      c_s[0] = cin;
      for (int i = 0; i < SLICE; i++) begin
         c_s[i + 1] = g_s[i] | (p_s[i] & c_s[i]);
      end
   end

   assign d    = p_s ^ c_s[SLICE-1:0];
   assign cout = c_s[SLICE];
endmodule

// File: rtl/sub_seq_slice_32_bit.sv
// Multi-cycle subtractor: diff = a - b computed one SLICE-bit chunk per
// clock, LSB first, with the borrow carried between chunks in a register.
module sub_seq_slice_32_bit
   import sub_seq_slice_32_bit_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SLICE = DEF_SLICE
) (
   input  logic                 clk,
   input  logic                 rst_n,
   sub_seq_slice_32_bit_if.slave bus
);
   localparam int NSLICE = WIDTH / SLICE;
   localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

   state_t           state_r;
   state_t           state_next_s;
   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] diff_r;
   logic [WIDTH-1:0] diff_next_s;
   logic             carry_r;
   logic             out_valid_r;
   logic             borrow_r;
   logic             overflow_r;
   logic             zero_r;

   logic [SLICE-1:0] a_slice_s;
   logic [SLICE-1:0] b_slice_s;
   logic [SLICE-1:0] d_slice_s;
   logic             c_next_s;
   logic             last_s;

   assign last_s = (cnt_r == LAST_CNT);

   // Pick the current operand chunks and merge the new difference chunk
   // into the partial result.
   always_comb begin
      a_slice_s   = a_r[cnt_r * SLICE +: SLICE];
      b_slice_s   = b_r[cnt_r * SLICE +: SLICE];
      diff_next_s = diff_r;
      diff_next_s[cnt_r * SLICE +: SLICE] = d_slice_s;
   end

   sub_slice_8_bit #(.SLICE(SLICE)) u_slice (
      .a    (a_slice_s),
      .b    (b_slice_s),
      .cin  (carry_r),
      .d    (d_slice_s),
      .cout (c_next_s)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state: accept in IDLE, NSLICE chunk cycles, hold result in DONE.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.in_valid) begin
               state_next_s = RUN;
            end else begin
               state_next_s = IDLE;
            end
         end
         RUN: begin
            if (last_s) begin
               state_next_s = DONE;
            end else begin
               state_next_s = RUN;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = DONE;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // Operand capture, chunk accumulation and registered result flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r       <= {CNT_W{1'b0}};
         a_r         <= {WIDTH{1'b0}};
         b_r         <= {WIDTH{1'b0}};
         diff_r      <= {WIDTH{1'b0}};
         carry_r     <= 1'b0;
         out_valid_r <= 1'b0;
         borrow_r    <= 1'b0;
         overflow_r  <= 1'b0;
         zero_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.in_valid) begin
                  a_r         <= bus.a;
                  b_r         <= bus.b;
                  cnt_r       <= {CNT_W{1'b0}};
                  carry_r     <= 1'b1;
                  diff_r      <= {WIDTH{1'b0}};
                  out_valid_r <= 1'b0;
                  borrow_r    <= 1'b0;
                  overflow_r  <= 1'b0;
                  zero_r      <= 1'b0;
               end
            end
            RUN: begin
               diff_r  <= diff_next_s;
               carry_r <= c_next_s;
               cnt_r   <= cnt_r + {{(CNT_W - 1){1'b0}}, 1'b1};
               if (last_s) begin
                  out_valid_r <= 1'b1;
                  borrow_r    <= ~c_next_s;
                  overflow_r  <= signed_ovf(a_r[WIDTH-1], b_r[WIDTH-1],
                                            diff_next_s[WIDTH-1]);
                  zero_r      <= ~|diff_next_s;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready   = (state_r == IDLE);
   assign bus.out_valid  = out_valid_r;
   assign bus.diff       = diff_r;
   assign bus.borrow_out = borrow_r;
   assign bus.overflow   = overflow_r;
   assign bus.zero       = zero_r;

endmodule

// File: doc/sub_seq_slice_32_bit.md
Name: sub_seq_slice_32_bit

Overview:
Multi-cycle two's-complement subtractor computing DIFF = A - B, one SLICE-bit chunk per clock, LSB slice first. The borrow is chained through a register between slices. It is the inverse-operation companion to the team's carry-lookahead adder datapath, and it trades latency for area in the ALU's subtract path. Operands arrive on a valid/ready input handshake; results leave on a valid/ready output handshake.

Parameters:
- WIDTH, 32, operand and result width; must be a positive multiple of SLICE.
- SLICE, 8, bits processed per cycle.
- NSLICE (localparam), WIDTH/SLICE, number of RUN cycles per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands on a/b are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- out_valid  output  1  result fields are valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  a - b modulo 2^WIDTH.
- borrow_out  output  1  1 when unsigned a < b.
- overflow  output  1  signed overflow of a - b.
- zero  output  1  diff == 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State returns to IDLE; slice counter and operand registers clear.
  - Outputs: in_ready=1 once state is IDLE; out_valid=0, diff=0, borrow_out=0, overflow=0, zero=0.
  - Any in-flight operation is discarded, and no result is produced for it.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid&&in_ready at a clock edge: latch a and b, set cnt=0, set carry register=1 (A + ~B + 1), go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, slice k=cnt computes {c_next, d_k} = a[k] + ~b[k] + carry.
  - d_k is written into diff bits [k*SLICE +: SLICE]; carry <= c_next; cnt <= cnt+1.
  - When cnt==NSLICE-1 the transfer completes and the state goes to DONE.
- DONE:
  - out_valid=1.
  - borrow_out = ~carry (final carry).
  - overflow = (a_msb != b_msb) && (diff_msb != a_msb), using the latched operands.
  - zero = ~|diff.
  - When out_ready=1: go to IDLE and drop out_valid at that edge.
  - No new operand is accepted in the same cycle as result acceptance.
- Latency: operands accepted at edge T, so out_valid=1 during the cycle following edge T+NSLICE (4 cycles for the defaults). Throughput is one operation per NSLICE+2 cycles minimum.
- Backpressure: while out_valid && !out_ready, diff, borrow_out, overflow and zero hold stable, and in_ready stays 0.
- Changes on a/b after acceptance have no effect.
- diff bits not yet computed are 0 during RUN (cleared at accept). diff, borrow_out, overflow and zero are only meaningful while out_valid=1.
- Flag outputs are registered or derived from registered state only; there is no combinational path from in_valid or out_ready to out_valid.
- in_ready may depend combinationally on state only.

Decomposition:
- Shared ALU package:
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Default WIDTH/SLICE constants.
- One combinational sub-module, sub_slice_8_bit (parameterized by SLICE):
  - Inputs: a slice, b slice, carry-in. Outputs: difference slice, carry-out.
  - Internally uses generate/propagate lookahead on a and ~b, consistent with the team's adder slices.
- Top level holds the FSM, the counter, the carry register, and the operand/result registers.

Test Plan:
- a=0x00000005, b=0x00000003, out_ready=1 -> out_valid exactly 4 cycles after accept; diff=0x00000002, borrow_out=0, overflow=0, zero=0.
- a=0x00000003, b=0x00000005 -> diff=0xFFFFFFFE, borrow_out=1, overflow=0, zero=0.
- a=0x80000000, b=0x00000001 -> diff=0x7FFFFFFF, borrow_out=0, overflow=1. Then a=0x7FFFFFFF, b=0xFFFFFFFF -> diff=0x80000000, borrow_out=1, overflow=1.
- a=0x12345678, b=0x12345678 -> diff=0, zero=1, borrow_out=0. Then a=0x00000100, b=0x00000001 -> diff=0x000000FF, which checks borrow propagation across the slice boundary.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> outputs stable and in_ready=0 throughout. A concurrent in_valid=1 with a new operand is not accepted until after the result is taken.
- Reset: assert rst_n=0 during the 2nd RUN cycle -> out_valid, diff and flags go to 0 immediately. After release, in_ready=1 and a fresh operation (0x10-0x01 -> 0x0000000F) completes correctly.
